rv_lsu: RTL
===========

Name: rv_lsu

Overview:
- Multi-cycle load/store unit sitting directly downstream of the execute stage.
- Replaces the zero-latency data-memory access path with a valid/ready request / response data-bus interface.
- Takes the ALU address, store data (rs2), func3 and the MemRead/MemWrite controls; drives the bus.
- Returns aligned, sign/zero-extended load data to write-back and stalls the core (PC update) until the access completes.

Parameters:
- TIMEOUT, 255: cycles allowed in WAIT_RSP before a bus timeout error; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  load requested by current instruction
- mem_write  in  1  store requested by current instruction
- func3  in  3  RV32I load/store width/sign code
- addr  in  32  byte address (ALU result)
- store_data  in  32  rs2 value
- load_data  out  32  extended load result, registered
- stall  out  1  core must hold PC/instruction
- done  out  1  one-cycle completion pulse
- err  out  1  with done: misaligned, illegal func3, bus error or timeout
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- req_be  out  4  byte enables
- req_wdata  out  32  lane-replicated store data
- rsp_valid  in  1  bus response valid
- rsp_rdata  in  32  read word
- rsp_err  in  1  bus error with response

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- Access requested: acc = mem_read | mem_write.
- stall: combinational, = (IDLE & acc) | REQ | WAIT_RSP; 0 in DONE.
- Every access takes ≥2 cycles.
- IDLE, no acc: remain.
- IDLE, acc: latch func3, addr[1:0] and we=mem_write.
  - Fault: mem_read&mem_write, misaligned, or illegal func3 → DONE with err=1, no bus request.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Illegal func3: load 011/110/111; store ≥011.
  - Otherwise compute req_* and go REQ.
- req_be:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<addr[1:0]
  - SW: 4'b1111
  - Loads: computed identically; bus may ignore.
- req_wdata: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2; 0 for loads.
- REQ: req_valid=1; req_we/addr/be/wdata registered and stable until req_ready. On req_valid&req_ready → WAIT_RSP; req_valid deasserts the next cycle.
- WAIT_RSP:
  - Counter increments each cycle.
  - On rsp_valid → DONE, with err=rsp_err.
  - For loads without rsp_err: load_data = extract(rsp_rdata).
  - If TIMEOUT≠0 and counter reaches TIMEOUT with no rsp_valid → DONE, err=1, load_data=0.
  - rsp_valid in IDLE, REQ or DONE is ignored.
- extract: w = rsp_rdata >> (8*addr[1:0]).
  - LB: sext w[7:0]; LBU: zext w[7:0]
  - LH: sext w[15:0]; LHU: zext w[15:0]
  - LW: w
- DONE: done=1, err valid, stall=0; load_data valid. Next state IDLE unconditionally; counter cleared.
- Stores and faults: load_data=0.
- load_data holds its value until the next DONE.
- Back-to-back: an access present in the IDLE cycle after DONE starts immediately; no idle bubble is required beyond the DONE cycle.
- Reset mid-operation: abandons the transaction; a late rsp_valid after reset is ignored (FSM in IDLE).

Test Plan:
1. LW addr=0x100, req_ready=1 immediately, rsp 2 cycles later with 0xDEADBEEF → req_addr=0x100, be=1111, we=0; done with load_data=0xDEADBEEF, err=0; stall high 4 cycles.
2. LB addr=0x103 with rsp_rdata=0x80112233 → load_data=0xFFFFFF80. LBU same → 0x00000080. LH addr=0x102 → 0xFFFF8011.
3. SB addr=0x201, rs2=0x123456AB, req_ready low 3 cycles → req_valid and payload held stable; be=0010, wdata=0xABABABAB, addr=0x200; done after rsp.
4. LW addr=0x102; SH addr=0x1; func3=011 load; mem_read&mem_write both set → no req_valid ever; done&err one cycle after request; load_data=0.
5. TIMEOUT=4, LW accepted, no rsp → done&err exactly 4 cycles into WAIT_RSP. Separately, rsp_err=1 → err=1.
6. Assert rst_n=0 during WAIT_RSP, release, then pulse rsp_valid → no done, state IDLE, outputs 0. A following LW completes normally.

Source files
------------

// File: rtl/rv_lsu.sv
// rv_lsu -- multi-cycle load/store unit between execute and write-back.
//
// Turns a single-instruction memory access (MemRead/MemWrite, func3, ALU
// address, rs2) into one valid/ready request on a data bus, waits for the
// response and returns the aligned, extended load word. The core is stalled
// from the first cycle of the access until the DONE cycle.
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   mem_read, mem_write   access request from the current instruction
//   func3                 RV32I width/sign code
//   addr                  byte address (ALU result)
//   store_data            rs2 value
//   load_data             registered, extended load result (0 for stores/faults)
//   stall                 hold PC/instruction while the access is in flight
//   done, err             one-cycle completion pulse, error qualifier
//   req_*                 bus request channel (valid/ready, word-aligned)
//   rsp_*                 bus response channel (no backpressure)
//
// Parameter
//   TIMEOUT               cycles allowed waiting for a response, 0 = never
module rv_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    // Counter only has to reach TIMEOUT-1: the cycle it sits there is the
    // last one allowed in WAIT_RSP.
    localparam int unsigned CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

    state_t         state, state_n;
    lsu_req_t       req_q, req_c;
    logic [2:0]     func3_q;
    logic [1:0]     off_q;
    logic           err_q;
    logic [CW-1:0]  cnt;

    logic           acc, fault, illegal, misalign, to_hit;
    logic           is_hw, is_w;

    // Shift the addressed lane down to bit 0, then extend per func3.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{24{w[7]}},  w[7:0]};
            3'b100:  extract = {24'h0,       w[7:0]};
            3'b001:  extract = {{16{w[15]}}, w[15:0]};
            3'b101:  extract = {16'h0,       w[15:0]};
            default: extract = w;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Access decode (only meaningful in IDLE)
    // ---------------------------------------------------------------
    assign acc   = mem_read | mem_write;
    assign is_hw = (func3[1:0] == 2'b01);
    assign is_w  = (func3[1:0] == 2'b10);

    always_comb begin
        illegal = 1'b0;
        if (mem_write)
            illegal = (func3 >= 3'b011);
        else
            illegal = (func3 == 3'b011) || (func3[2:1] == 2'b11);
    end

    assign misalign = (is_hw & addr[0]) | (is_w & (addr[1:0] != 2'b00));
    assign fault    = (mem_read & mem_write) | illegal | misalign;

    always_comb begin
        req_c.we    = mem_write;
        req_c.addr  = {addr[31:2], 2'b00};
        req_c.be    = 4'b1111;
        req_c.wdata = 32'h0;
        case (func3[1:0])
            2'b00:   req_c.be = 4'b0001 << addr[1:0];
            2'b01:   req_c.be = 4'b0011 << addr[1:0];
            default: req_c.be = 4'b1111;
        endcase
        // Replicate store data across lanes so the bus can just apply be.
        if (mem_write) begin
            case (func3[1:0])
                2'b00:   req_c.wdata = {4{store_data[7:0]}};
                2'b01:   req_c.wdata = {2{store_data[15:0]}};
                default: req_c.wdata = store_data;
            endcase
        end
    end

    assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        stall     = 1'b0;
        req_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    stall   = 1'b1;
                    state_n = fault ? DONE : REQ;
                end
            end
            REQ: begin
                stall     = 1'b1;
                req_valid = 1'b1;
                if (req_ready) state_n = WAIT_RSP;
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (rsp_valid || to_hit) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign err       = done & err_q;
    assign req_we    = req_q.we;
    assign req_addr  = req_q.addr;
    assign req_be    = req_q.be;
    assign req_wdata = req_q.wdata;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            func3_q   <= 3'b000;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            load_data <= 32'h0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        req_q   <= req_c;
                        func3_q <= func3;
                        off_q   <= addr[1:0];
                        err_q   <= fault;
                        if (fault) load_data <= 32'h0;
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt + 1'b1;
                    // A response in the last allowed cycle wins over timeout.
                    if (rsp_valid) begin
                        err_q     <= rsp_err;
                        load_data <= (!req_q.we && !rsp_err) ?
                                     extract(func3_q, off_q, rsp_rdata) : 32'h0;
                    end else if (to_hit) begin
                        err_q     <= 1'b1;
                        load_data <= 32'h0;
                    end
                end
                DONE: cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule
